// File: rtl/alu_pkg.sv
// Shared opcode definitions for the pipelined register ALU.
// The datapath control FSM and the bench both decode Select through this package.
package alu_pkg;

  localparam int SEL_W = 3;

  typedef logic [SEL_W-1:0] op_t;

  localparam op_t OP_ADD  = 3'd0;
  localparam op_t OP_SUB  = 3'd1;
  localparam op_t OP_ADD3 = 3'd2;
  localparam op_t OP_ACC  = 3'd3;
  localparam op_t OP_AND  = 3'd4;
  localparam op_t OP_OR   = 3'd5;
  localparam op_t OP_XOR  = 3'd6;
  localparam op_t OP_PASS = 3'd7;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: all arithmetic for reg_alu_pipe lives here.
// Every result is truncated to WIDTH bits; carry is zero for the logic ops and PASS.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  op_t              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] acc,
  output logic [WIDTH-1:0] res,
  output logic             carry
);

  logic [WIDTH:0]   sum_ab;
  logic [WIDTH:0]   diff_ab;
  logic [WIDTH:0]   sum_acc;
  logic [WIDTH+1:0] sum_abc;

  always_comb begin
    sum_ab  = {1'b0, a} + {1'b0, b};
    diff_ab = {1'b0, a} - {1'b0, b};
    sum_acc = {1'b0, acc} + {1'b0, a};
    sum_abc = {2'b00, a} + {2'b00, b} + {2'b00, c};
    res     = '0;
    carry   = 1'b0;
    case (op)
      OP_ADD: begin
        res   = sum_ab[WIDTH-1:0];
        carry = sum_ab[WIDTH];
      end
      // Top bit of the widened difference is the borrow; carry means "no borrow".
      OP_SUB: begin
        res   = diff_ab[WIDTH-1:0];
        carry = ~diff_ab[WIDTH];
      end
      OP_ADD3: begin
        res   = sum_abc[WIDTH-1:0];
        carry = |sum_abc[WIDTH+1:WIDTH];
      end
      OP_ACC: begin
        res   = sum_acc[WIDTH-1:0];
        carry = sum_acc[WIDTH];
      end
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_PASS: res = c;
      default: begin
        res   = '0;
        carry = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/reg_alu_pipe.sv
// Two-stage valid/ready register ALU: S1 captures operands, S2 computes and holds the result.
// RegOut doubles as the accumulator, so ACC always sees the previous result in issue order.
module reg_alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [SEL_W-1:0] Select,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] RegOut,
  output logic             Carryout,
  output logic             Zero,
  output logic             out_valid,
  input  logic             out_ready
);

  logic             s1_valid_q, s1_valid_d;
  op_t              s1_op_q, s1_op_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  logic [WIDTH-1:0] s1_c_q, s1_c_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] regout_q, regout_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;

  logic             s2_free;
  logic             s1_adv;
  logic             accept;
  logic [WIDTH-1:0] core_res;
  logic             core_carry;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .op    (s1_op_q),
    .a     (s1_a_q),
    .b     (s1_b_q),
    .c     (s1_c_q),
    .acc   (regout_q),
    .res   (core_res),
    .carry (core_carry)
  );

  always_comb begin
    s2_free  = !out_valid_q || out_ready;
    s1_adv   = s1_valid_q && s2_free;
    in_ready = !s1_valid_q || s2_free;
    accept   = in_valid && in_ready;

    s1_valid_d  = accept || (s1_valid_q && !s1_adv);
    s1_op_d     = s1_op_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s1_c_d      = s1_c_q;
    out_valid_d = s1_adv || (out_valid_q && !out_ready);
    regout_d    = regout_q;
    carry_d     = carry_q;
    zero_d      = zero_q;

    if (accept) begin
      s1_op_d = op_t'(Select);
      s1_a_d  = A;
      s1_b_d  = B;
      s1_c_d  = C;
    end
    // Flags change only on a new S2 load; consumption alone leaves them intact.
    if (s1_adv) begin
      regout_d = core_res;
      carry_d  = core_carry;
      zero_d   = (core_res == '0);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_op_q     <= OP_ADD;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_c_q      <= '0;
      out_valid_q <= 1'b0;
      regout_q    <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b1;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_op_q     <= s1_op_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_c_q      <= s1_c_d;
      out_valid_q <= out_valid_d;
      regout_q    <= regout_d;
      carry_q     <= carry_d;
      zero_q      <= zero_d;
    end
  end

  assign RegOut    = regout_q;
  assign Carryout  = carry_q;
  assign Zero      = zero_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_reg_alu_pipe.sv
// Scoreboard bench for reg_alu_pipe at WIDTH=4: the stimulus pushes hand-computed
// results, a negedge monitor pops and compares every result the DUT hands over.
module tb_reg_alu_pipe;
  import alu_pkg::*;

  localparam int WIDTH = 4;

  typedef struct {
    logic [WIDTH-1:0] r;
    logic             c;
    logic             z;
  } exp_t;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [2:0]       Select = 3'd0;
  logic [WIDTH-1:0] A = '0, B = '0, C = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] RegOut;
  logic             Carryout, Zero, out_valid;
  logic             out_ready;

  logic man_rdy = 1'b1;
  logic rand_rdy = 1'b0;
  logic rnd_rdy = 1'b1;
  assign out_ready = rand_rdy ? rnd_rdy : man_rdy;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   model_acc = 0;
  exp_t sb[$];
  int   pop_cyc[$];

  reg_alu_pipe #(.WIDTH(WIDTH)) dut (
    .clock    (clock),
    .reset    (reset),
    .Select   (Select),
    .A        (A),
    .B        (B),
    .C        (C),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .RegOut   (RegOut),
    .Carryout (Carryout),
    .Zero     (Zero),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    cyc <= cyc + 1;
    #1 rnd_rdy = 1'($urandom_range(0, 1));
  end

  // Monitor: a result is consumed at the edge following a negedge with valid && ready.
  always @(negedge clock) begin
    if (!reset && out_valid && out_ready) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_result: got RegOut=%0d C=%0b Z=%0b, none expected", RegOut, Carryout, Zero);
      end else begin
        exp_t e;
        e = sb.pop_front();
        pop_cyc.push_back(cyc);
        if ({RegOut, Carryout, Zero} !== {e.r, e.c, e.z}) begin
          n_fail++;
          $display("FAIL result: got RegOut=%0d C=%0b Z=%0b, expected RegOut=%0d C=%0b Z=%0b",
                   RegOut, Carryout, Zero, e.r, e.c, e.z);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [2:0] op, input int a, input int b, input int c, input int acc);
    int   s;
    exp_t e;
    e.c = 1'b0;
    s = 0;
    case (op)
      3'd0: begin s = a + b;     e.c = (s > 15); end
      3'd1: begin s = a - b;     e.c = (a >= b); end
      3'd2: begin s = a + b + c; e.c = (s > 15); end
      3'd3: begin s = acc + a;   e.c = (s > 15); end
      3'd4: s = a & b;
      3'd5: s = a | b;
      3'd6: s = a ^ b;
      default: s = c;
    endcase
    e.r = s[3:0];
    e.z = (e.r == 4'd0);
    return e;
  endfunction

  // Presents an operand set, waits for acceptance, and queues its expected result.
  // Returns one time unit after the accepting edge with in_valid still asserted.
  task automatic issue_exp(input logic [2:0] op, input int a, input int b, input int c,
                           input int er, input bit ec);
    bit   ok;
    exp_t e;
    Select   = op;
    A        = a[3:0];
    B        = b[3:0];
    C        = c[3:0];
    in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      e.r = er[3:0];
      e.c = ec;
      e.z = (er[3:0] == 4'd0);
      sb.push_back(e);
      model_acc = int'(er[3:0]);
      @(posedge clock);
      #1;
    end else begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: in_ready stayed 0 for op %0d", op);
      in_valid = 1'b0;
    end
  endtask

  task automatic issue_rand();
    logic [2:0] op;
    int a, b, c;
    exp_t e;
    op = 3'($urandom_range(0, 7));
    a  = int'($urandom_range(0, 15));
    b  = int'($urandom_range(0, 15));
    c  = int'($urandom_range(0, 15));
    e  = model(op, a, b, c, model_acc);
    issue_exp(op, a, b, c, int'(e.r), e.c);
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clock);
      #1;
      if (sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: %0d results still outstanding", sb.size());
    end
    @(posedge clock);
    #1;
  endtask

  task automatic chk_consecutive(input string name, input int n);
    chk({name, "_count"}, pop_cyc.size(), n);
    for (int i = 1; i < pop_cyc.size(); i++)
      chk({name, "_gap"}, pop_cyc[i] - pop_cyc[i-1], 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_regout", int'(RegOut), 0);
    chk("reset_zero", int'(Zero), 1);
    chk("reset_carry", int'(Carryout), 0);
    reset = 1'b0;
    #1;
    chk("reset_in_ready", int'(in_ready), 1);
    @(posedge clock);
    #1;

    // Arithmetic boundaries.
    man_rdy = 1'b1;
    issue_exp(OP_ADD,  9, 8, 0,  1, 1'b1);
    issue_exp(OP_SUB,  3, 5, 0, 14, 1'b0);
    issue_exp(OP_SUB,  5, 5, 0,  0, 1'b1);
    issue_exp(OP_ADD3, 15, 15, 15, 13, 1'b1);
    issue_exp(OP_ADD3, 1, 2, 3, 6, 1'b0);
    in_valid = 1'b0;
    drain();

    // Accumulate chain back-to-back: one result per cycle.
    pop_cyc.delete();
    issue_exp(OP_PASS, 0, 0, 5,  5, 1'b0);
    issue_exp(OP_ACC,  3, 0, 0,  8, 1'b0);
    issue_exp(OP_ACC,  3, 0, 0, 11, 1'b0);
    issue_exp(OP_ACC,  7, 0, 0,  2, 1'b1);
    in_valid = 1'b0;
    drain();
    chk_consecutive("acc_chain", 4);

    // Stall: two ops are absorbed, the third is refused until out_ready returns.
    man_rdy = 1'b0;
    pop_cyc.delete();
    issue_exp(OP_XOR, 12, 10, 0, 6, 1'b0);
    issue_exp(OP_AND, 12, 10, 0, 8, 1'b0);
    Select = OP_OR;
    A = 4'd12;
    B = 4'd10;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("stall_in_ready", int'(in_ready), 0);
      chk("stall_out_valid", int'(out_valid), 1);
      chk("stall_regout_hold", int'(RegOut), 6);
    end
    @(posedge clock);
    #1;
    man_rdy = 1'b1;
    issue_exp(OP_OR, 12, 10, 0, 14, 1'b0);
    in_valid = 1'b0;
    drain();
    chk_consecutive("stall_release", 3);
    chk("hold_after_consume_regout", int'(RegOut), 14);
    chk("hold_after_consume_valid", int'(out_valid), 0);

    // Reset with both stages full and operands still presented.
    man_rdy = 1'b0;
    issue_exp(OP_PASS, 0, 0, 9, 9, 1'b0);
    issue_exp(OP_XOR, 3, 5, 0, 6, 1'b0);
    Select = OP_PASS;
    C = 4'd7;
    reset = 1'b1;
    @(posedge clock);
    #1;
    sb.delete();
    model_acc = 0;
    chk("midstall_reset_out_valid", int'(out_valid), 0);
    chk("midstall_reset_regout", int'(RegOut), 0);
    chk("midstall_reset_zero", int'(Zero), 1);
    chk("midstall_reset_carry", int'(Carryout), 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("post_reset_in_ready", int'(in_ready), 1);
    @(posedge clock);
    #1;
    chk("reset_inputs_ignored", int'(out_valid), 0);
    man_rdy = 1'b1;
    issue_exp(OP_ACC, 4, 0, 0, 4, 1'b0);
    in_valid = 1'b0;
    drain();

    // Random ops against the model with random backpressure.
    rand_rdy = 1'b1;
    for (int i = 0; i < 80; i++) begin
      issue_rand();
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(posedge clock);
        #1;
      end
    end
    in_valid = 1'b0;
    rand_rdy = 1'b0;
    man_rdy  = 1'b1;
    drain();
    chk("scoreboard_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
